clb_slice: RTL and testbench

- Parametrised configurable logic slice for the soft-FPGA fabric.
- NUM_LUTS K-input LUTs feed an output mux; the mux output drives a clock-enabled output flop that can be bypassed.
- Truth tables are loaded over a serial valid/ready config chain into a shadow register, then committed atomically, so reconfiguration never glitches live outputs.

---
 rtl/clb_slice.sv | 134 +++++++++++++
 tb/tb_clb_slice.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clb_slice.sv
// Configurable logic slice: NUM_LUTS K-input LUTs, output mux, and an optional output flop.
// Truth tables load serially into a shadow register and commit atomically; macro CFG_CHAIN_OUT_EN adds cfg_dout.
module clb_slice #(
    parameter int K        = 4,
    parameter int NUM_LUTS = 2,
    parameter int SEL_W    = $clog2(NUM_LUTS),
    parameter int CFG_BITS = NUM_LUTS * (2 ** K) + 1
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  cfg_start,
    input  logic                  cfg_valid,
    input  logic                  cfg_data,
    output logic                  cfg_ready,
    output logic                  cfg_done,
    input  logic [NUM_LUTS*K-1:0] lut_in,
    input  logic [SEL_W-1:0]      lut_sel,
    input  logic                  ce,
    output logic [NUM_LUTS-1:0]   lut_out,
    output logic                  outA,
    output logic                  outB,
    output logic [1:0]            cfg_state
`ifdef CFG_CHAIN_OUT_EN
    ,
    output logic                  cfg_dout
`endif
);

    localparam int LUT_D = 2 ** K;
    localparam int CNT_W = $clog2(CFG_BITS);

    typedef enum logic [1:0] {
        UNCFG  = 2'd0,
        LOAD   = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CFG_BITS-1:0] shadow_q, active_q, shadow_next;
    logic                done_q;
    logic                outb_q;
    logic                shift, commit;

    // Handshake: a config bit transfers on a rising CLK edge when cfg_valid and
    // cfg_ready are both high; cfg_start in the same cycle takes priority and
    // the bit is dropped.
    assign shadow_next = {shadow_q[CFG_BITS-2:0], cfg_data};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift     = 1'b0;
        commit    = 1'b0;
        cfg_ready = 1'b0;
        case (state_q)
            UNCFG: begin
                if (cfg_start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                cfg_ready = 1'b1;
                if (cfg_start) begin
                    cnt_d = '0;
                end else if (cfg_valid) begin
                    shift = 1'b1;
                    if (cnt_q == CNT_W'(CFG_BITS - 1)) begin
                        commit  = 1'b1;
                        state_d = ACTIVE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ACTIVE: begin
                if (cfg_start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end
            default: state_d = UNCFG;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= UNCFG;
            cnt_q    <= '0;
            shadow_q <= '0;
            active_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (shift) shadow_q <= shadow_next;
            if (commit) begin
                active_q <= shadow_next;
                done_q   <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_LUTS; i++) begin : g_lut
        logic [LUT_D-1:0] tt;
        assign tt         = active_q[i*LUT_D +: LUT_D];
        assign lut_out[i] = done_q & tt[lut_in[i*K +: K]];
    end

    assign outA = lut_out[lut_sel];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            outb_q <= 1'b0;
        end else if (ce && done_q) begin
            outb_q <= outA;
        end
    end

    // Bypass bypasses the flop on the output only; the flop keeps sampling.
    assign outB      = active_q[CFG_BITS-1] ? outA : outb_q;
    assign cfg_done  = done_q;
    assign cfg_state = state_q;

`ifdef CFG_CHAIN_OUT_EN
    assign cfg_dout = shadow_q[CFG_BITS-1];
`else
    logic unused_shadow_msb;
    assign unused_shadow_msb = shadow_q[CFG_BITS-1];
`endif

endmodule

// File: tb/tb_clb_slice.sv
// Directed bench for clb_slice with K=2, NUM_LUTS=2 (9 config bits).
// With CFG_CHAIN_OUT_EN a second slice is chained behind the DUT.
module tb_clb_slice;

    localparam int K = 2;
    localparam int NL = 2;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       cfg_start = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_data = 1'b0;
    logic       cfg_ready;
    logic       cfg_done;
    logic [3:0] lut_in = 4'b0;
    logic       lut_sel = 1'b0;
    logic       ce = 1'b0;
    logic [1:0] lut_out;
    logic       outA;
    logic       outB;
    logic [1:0] cfg_state;

    int n_checks = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

`ifdef CFG_CHAIN_OUT_EN
    logic       cfg_dout, b_ready, b_done, b_outA, b_outB, b_dout;
    logic [1:0] b_lut_out, b_state;
`endif

    clb_slice #(.K(K), .NUM_LUTS(NL)) dut (
        .CLK(CLK), .RST_N(RST_N), .cfg_start(cfg_start), .cfg_valid(cfg_valid),
        .cfg_data(cfg_data), .cfg_ready(cfg_ready), .cfg_done(cfg_done),
        .lut_in(lut_in), .lut_sel(lut_sel), .ce(ce), .lut_out(lut_out),
        .outA(outA), .outB(outB), .cfg_state(cfg_state)
`ifdef CFG_CHAIN_OUT_EN
        , .cfg_dout(cfg_dout)
`endif
    );

`ifdef CFG_CHAIN_OUT_EN
    clb_slice #(.K(K), .NUM_LUTS(NL)) dut_b (
        .CLK(CLK), .RST_N(RST_N), .cfg_start(cfg_start), .cfg_valid(cfg_valid),
        .cfg_data(cfg_dout), .cfg_ready(b_ready), .cfg_done(b_done),
        .lut_in(lut_in), .lut_sel(lut_sel), .ce(ce), .lut_out(b_lut_out),
        .outA(b_outA), .outB(b_outB), .cfg_state(b_state), .cfg_dout(b_dout)
    );
`endif

    typedef struct {
        logic [3:0] li;
        logic       sel;
        logic [1:0] lo;
        logic       oa;
    } vec_t;

    vec_t vecs[7];

    // {bypass, LUT1 table, LUT0 table}; sent MSB first.
    localparam logic [8:0] W_AX  = 9'b0_0110_1000;
    localparam logic [8:0] W_BYP = 9'b1_0110_1000;
    localparam logic [8:0] W_ON  = 9'b0_1110_0111;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic start_load();
        cfg_start = 1'b1;
        @(negedge CLK);
        cfg_start = 1'b0;
    endtask

    task automatic send_bits(input logic [8:0] w, input int first, input int n);
        for (int i = first; i < first + n; i++) begin
            cfg_valid = 1'b1;
            cfg_data  = w[8-i];
            @(negedge CLK);
        end
        cfg_valid = 1'b0;
        cfg_data  = 1'b0;
    endtask

    task automatic apply(input logic [3:0] li, input logic sel);
        lut_in  = li;
        lut_sel = sel;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{4'b1111, 1'b0, 2'b01, 1'b1};
        vecs[1] = '{4'b1111, 1'b1, 2'b01, 1'b0};
        vecs[2] = '{4'b0111, 1'b1, 2'b11, 1'b1};
        vecs[3] = '{4'b1001, 1'b0, 2'b10, 1'b0};
        vecs[4] = '{4'b0000, 1'b1, 2'b00, 1'b0};
        vecs[5] = '{4'b1110, 1'b0, 2'b00, 1'b0};
        vecs[6] = '{4'b0110, 1'b1, 2'b10, 1'b1};

        // Reset and unconfigured behaviour
        ce = 1'b1;
        repeat (2) @(negedge CLK);
        check("rst_done", cfg_done, 0);
        check("rst_ready", cfg_ready, 0);
        check("rst_outB", outB, 0);
        check("rst_state", cfg_state, 0);
        RST_N = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            apply(vecs[i].li, vecs[i].sel);
            check("uncfg_lut_out", lut_out, 0);
            check("uncfg_outA", outA, 0);
            check("uncfg_outB", outB, 0);
            check("uncfg_ready", cfg_ready, 0);
        end
        ce = 1'b0;

        // Full load of AND/XOR table
        @(negedge CLK);
        start_load();
        check("load_ready", cfg_ready, 1);
        check("load_state", cfg_state, 1);
        send_bits(W_AX, 0, 8);
        check("pre_commit_done", cfg_done, 0);
        check("pre_commit_lut_out", lut_out, 0);
        send_bits(W_AX, 8, 1);
        check("commit_done", cfg_done, 1);
        check("commit_ready", cfg_ready, 0);
        check("commit_state", cfg_state, 2);

        for (int i = 0; i < 7; i++) begin
            apply(vecs[i].li, vecs[i].sel);
            check("vec_lut_out", lut_out, vecs[i].lo);
            check("vec_outA", outA, vecs[i].oa);
            check("vec_outB_held", outB, 0);
        end

        // Registered path: one cycle latency, then hold with ce=0
        @(negedge CLK);
        apply(4'b1111, 1'b0);
        ce = 1'b1;
        check("reg_before_edge", outB, 0);
        @(negedge CLK);
        check("reg_after_edge", outB, 1);
        ce = 1'b0;
        for (int i = 0; i < 3; i++) begin
            apply(4'b1111, i[0] ? 1'b0 : 1'b1);
            @(negedge CLK);
            check("reg_hold_ce0", outB, 1);
        end

        // Bypass config: outB follows outA combinationally
        start_load();
        send_bits(W_BYP, 0, 9);
        apply(4'b1111, 1'b1);
        check("byp_outA_lo", outA, 0);
        check("byp_outB_lo", outB, 0);
        apply(4'b1111, 1'b0);
        check("byp_outB_hi", outB, 1);

        // Reload from ACTIVE with an aborted partial load; start wins over a bit
        apply(4'b0110, 1'b1);
        @(negedge CLK);
        start_load();
        send_bits(W_ON, 0, 5);
        check("partial1_lut_out", lut_out, 2'b10);
        cfg_start = 1'b1;
        cfg_valid = 1'b1;
        cfg_data  = 1'b1;
        @(negedge CLK);
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        check("abort_state", cfg_state, 1);
        send_bits(W_ON, 0, 8);
        check("partial2_lut_out", lut_out, 2'b10);
        check("partial2_outB_byp", outB, 1);
        check("partial2_state", cfg_state, 1);
        send_bits(W_ON, 8, 1);
        check("reload_lut_out", lut_out, 2'b11);
        check("reload_state", cfg_state, 2);
        check("reload_outB_reg", outB, 1);

        // Asynchronous reset in the middle of a load
        start_load();
        send_bits(W_AX, 0, 4);
        #2;
        RST_N = 1'b0;
        #1;
        check("midrst_done", cfg_done, 0);
        check("midrst_outB", outB, 0);
        check("midrst_lut_out", lut_out, 0);
        check("midrst_state", cfg_state, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        start_load();
        send_bits(W_AX, 0, 9);
        apply(4'b0111, 1'b1);
        check("postrst_lut_out", lut_out, 2'b11);
        check("postrst_done", cfg_done, 1);

`ifdef CFG_CHAIN_OUT_EN
        begin
            logic [8:0]  sh_a;
            logic [17:0] stream;
            stream = {W_ON, W_AX};
            RST_N = 1'b0;
            @(negedge CLK);
            RST_N = 1'b1;
            sh_a = '0;
            @(negedge CLK);
            for (int pass = 0; pass < 2; pass++) begin
                start_load();
                for (int i = 0; i < 9; i++) begin
                    cfg_valid = 1'b1;
                    cfg_data  = stream[17 - (pass * 9 + i)];
                    @(negedge CLK);
                    sh_a = {sh_a[7:0], stream[17 - (pass * 9 + i)]};
                    check("chain_dout", cfg_dout, sh_a[8]);
                end
                cfg_valid = 1'b0;
            end
            apply(4'b0110, 1'b1);
            check("chain_a_lut_out", lut_out, 2'b10);
            check("chain_b_lut_out", b_lut_out, 2'b11);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
